fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter and drives a synchronous-read instruction ROM. It presents one 9-bit instruction per cycle to the decoder, applies taken branches/jumps with zero bubble, and halts on the terminate instruction. It also keeps a retired-instruction counter for performance checks.

Parameters:
PC_W, 8, program counter / ROM address width
START_ADDR, 0, PC value fetched first after start
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin execution from START_ADDR; honoured in IDLE and HALT only
stall  input  1  freeze fetch; current instruction held
branch  input  1  decoder branch signal for the instruction on inst
take  input  1  branch condition (R0 flag); redirect only when branch=1
target  input  PC_W  branch/jump destination address
imem_addr  output  PC_W  ROM read address (combinational)
imem_en  output  1  ROM read enable; ROM output holds when 0
imem_data  input  9  ROM read data, valid one cycle after an enabled read
inst  output  9  instruction to decoder; imem_data when inst_valid, else 0
inst_valid  output  1  inst is a live instruction
inst_pc  output  PC_W  address of the instruction on inst
done  output  1  program terminated
inst_count  output  CNT_W  retired instructions since last start, saturating

Behaviour:
- States: IDLE, RUN, HALT. Registers: state, fetch_pc (next sequential address), inst_pc, done, inst_count.
- Reset (synchronous, any state): state=IDLE, fetch_pc=START_ADDR, inst_pc=0, done=0, inst_count=0. Outputs: imem_en=0, inst_valid=0, inst=0.
- inst_valid = (state==RUN). The ROM has 1-cycle latency and inst_pc is registered with the issued address, so inst and inst_pc are always aligned.
- Derived signals, active in RUN only:
  - term = inst_valid & inst[8] & (inst[2:0]==6).
  - redirect = inst_valid & branch & take.
- IDLE, or HALT with start=1:
  - imem_addr=START_ADDR, imem_en=1.
  - Next cycle: inst_pc=START_ADDR, fetch_pc=START_ADDR+1, inst_count=0, done=0, state=RUN.
- IDLE, or HALT with start=0: imem_en=0, imem_addr=fetch_pc, and nothing changes.
- RUN priority is stall > term > redirect > sequential:
  - stall=1: imem_en=0, all registers hold, inst and inst_pc unchanged, count unchanged. term and redirect are ignored until stall drops.
  - term: imem_en=0. Next cycle: state=HALT, done=1, count+1.
  - redirect: imem_addr=target, imem_en=1. Next cycle: inst_pc=target, fetch_pc=target+1, count+1. No bubble.
  - otherwise: imem_addr=fetch_pc, imem_en=1. Next cycle: inst_pc=fetch_pc, fetch_pc+1, count+1.
- branch=1 with take=0 falls through as sequential.
- start is ignored while in RUN.
- PC arithmetic is modulo 2^PC_W: 2^PC_W-1 wraps to 0, with no flag.
- inst_count saturates at all-ones. The terminate instruction is counted; stalled cycles are not.
- HALT: done stays 1, inst_valid=0, imem_en=0 until start or reset.
- Reset asserted mid-RUN or during stall overrides everything the same cycle and returns to IDLE.

Test Plan:
1. Reset, then start=1 for one cycle; ROM[0..3] hold add instructions (0x000) -> inst_pc is 0,1,2,3 on consecutive cycles, inst_valid=1 from the cycle after start, inst_count=4 after the 4th.
2. Branch at inst_pc=2 with take=1, target=0x10 -> imem_addr=0x10 that cycle, next cycle inst_pc=0x10, then 0x11. Repeat with take=0 -> next inst_pc=3.
3. Hold stall=1 for 2 cycles while inst_pc=5 -> imem_en=0, inst and inst_pc held at 5, inst_count unchanged. After release, inst_pc=6.
4. ROM[7]=0x106 (terminate), sequential run from 0 -> the cycle after inst_pc=7: done=1, inst_valid=0, inst=0, inst_count=8, imem_en stays 0. Also assert stall during terminate -> halt is delayed until stall drops.
5. PC_W=4, START_ADDR=14, sequential -> inst_pc 14,15,0,1. Branch with target=15 -> next inst_pc=15, then 0.
6. Assert reset mid-RUN at inst_pc=3 -> next cycle IDLE, inst_valid=0, count=0. Separately, start=1 while in HALT -> done=0, count=0, inst_pc=START_ADDR next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives a synchronous-read
// instruction ROM, presents one instruction per cycle to the decoder, applies
// taken branches with no bubble, halts on the terminate instruction and keeps
// a saturating retired-instruction counter.
module fetch_unit #(
  parameter int unsigned PC_W       = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch,
  input  logic             take,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_en,
  input  logic [8:0]       imem_data,
  output logic [8:0]       inst,
  output logic             inst_valid,
  output logic [PC_W-1:0]  inst_pc,
  output logic             done,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] fetch_pc;
  logic            vld_p1;
  logic            term;
  logic            redirect;
  logic            issue;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ---- stage p1: instruction returned by the ROM, tagged by inst_pc ----
  assign vld_p1     = (state == RUN);
  assign inst_valid = vld_p1;
  assign inst       = vld_p1 ? imem_data : 9'd0;

  // Decode the two events the fetch stage reacts to, and pick the next read.
  always_comb begin
    term      = vld_p1 & inst[8] & (inst[2:0] == 3'd6);
    redirect  = vld_p1 & branch & take;
    imem_en   = 1'b0;
    imem_addr = fetch_pc;
    issue     = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          imem_en   = 1'b1;
          imem_addr = START_PC;
        end
      end
      RUN: begin
        if (!stall && !term) begin
          issue     = 1'b1;
          imem_en   = 1'b1;
          imem_addr = redirect ? target : fetch_pc;
        end
      end
      default: begin
        imem_en   = 1'b0;
        imem_addr = fetch_pc;
      end
    endcase
  end

  // ---- stage p0 -> p1: PC, state and retirement bookkeeping ----
  // Control FSM: start/run/halt sequencing plus PC and counter updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= START_PC;
      inst_pc    <= '0;
      done       <= 1'b0;
      inst_count <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state      <= RUN;
            inst_pc    <= START_PC;
            fetch_pc   <= START_PC + PC_ONE;
            inst_count <= '0;
            done       <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            inst_count <= sat_inc(inst_count);
            if (term) begin
              state <= HALT;
              done  <= 1'b1;
            end else if (issue) begin
              inst_pc  <= imem_addr;
              fetch_pc <= imem_addr + PC_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default 8-bit instance with a 16-bit
// counter, and a 4-bit-PC instance starting at 14 with a 3-bit counter so
// wrap-around and counter saturation are reachable in a few cycles.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- 8-bit instance ----------------
  logic        reset, start, stall, branch, take;
  logic [7:0]  target, imem_addr, inst_pc;
  logic        imem_en, inst_valid, done;
  logic [8:0]  imem_data, inst;
  logic [15:0] inst_count;
  logic [8:0]  rom [256];

  fetch_unit #(.PC_W(8), .START_ADDR(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch(branch), .take(take), .target(target),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
    .inst(inst), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .done(done), .inst_count(inst_count)
  );

  always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

  // ---------------- 4-bit instance ----------------
  logic       reset4, start4, stall4, branch4, take4;
  logic [3:0] target4, imem_addr4, inst_pc4;
  logic       imem_en4, inst_valid4, done4;
  logic [8:0] imem_data4, inst4;
  logic [2:0] inst_count4;

  fetch_unit #(.PC_W(4), .START_ADDR(14), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .stall(stall4),
    .branch(branch4), .take(take4), .target(target4),
    .imem_addr(imem_addr4), .imem_en(imem_en4), .imem_data(imem_data4),
    .inst(inst4), .inst_valid(inst_valid4), .inst_pc(inst_pc4),
    .done(done4), .inst_count(inst_count4)
  );

  always @(posedge clk) if (imem_en4) imem_data4 <= 9'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic restart;
    reset = 1'b1; tick; reset = 1'b0;
    start = 1'b1; tick; start = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    rom[1] = 9'h155;  // bit8 set but low bits 5: not terminate
    rom[3] = 9'h006;  // low bits 6 but bit8 clear: not terminate
    rom[5] = 9'h0C3;
    rom[7] = 9'h106;  // terminate
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; take = 1'b0; target = '0;
    reset4 = 1'b0; start4 = 1'b0; stall4 = 1'b0; branch4 = 1'b0; take4 = 1'b0; target4 = '0;

    // Reset state
    reset = 1'b1; reset4 = 1'b1; tick; reset = 1'b0; reset4 = 1'b0; #1;
    chk("rst_valid", inst_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_count", inst_count, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_en", imem_en, 0);
    chk("rst4_addr", imem_addr4, 14);

    // Start and sequential fetch
    start = 1'b1; #1;
    chk("start_en", imem_en, 1);
    chk("start_addr", imem_addr, 0);
    tick; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("seq_pc", inst_pc, i);
      chk("seq_count", inst_count, i);
      chk("seq_valid", inst_valid, 1);
      chk("seq_inst", inst, rom[i]);
      if (i < 4) begin
        #1;
        chk("seq_addr", imem_addr, i + 1);
        tick;
      end
    end

    // Taken branch at pc 2
    restart; tick; tick;
    chk("br_pc2", inst_pc, 2);
    branch = 1'b1; take = 1'b1; target = 8'h10; #1;
    chk("br_addr", imem_addr, 8'h10);
    chk("br_en", imem_en, 1);
    tick; branch = 1'b0; take = 1'b0;
    chk("br_pc_tgt", inst_pc, 8'h10);
    chk("br_count", inst_count, 3);
    tick;
    chk("br_pc_tgt1", inst_pc, 8'h11);

    // Not-taken branch at pc 2
    restart; tick; tick;
    branch = 1'b1; take = 1'b0; target = 8'h40; #1;
    chk("nt_addr", imem_addr, 3);
    tick; branch = 1'b0;
    chk("nt_pc", inst_pc, 3);

    // Stall for two cycles at pc 5, with a taken branch pending
    restart; repeat (5) tick;
    chk("st_pc5", inst_pc, 5);
    stall = 1'b1; branch = 1'b1; take = 1'b1; target = 8'h20; #1;
    chk("st_en", imem_en, 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("st_pc_hold", inst_pc, 5);
      chk("st_inst_hold", inst, 9'h0C3);
      chk("st_count_hold", inst_count, 5);
    end
    stall = 1'b0; branch = 1'b0; take = 1'b0;
    tick;
    chk("st_pc6", inst_pc, 6);
    chk("st_count6", inst_count, 6);

    // Terminate at pc 7, delayed one cycle by stall, with a branch pending
    restart; repeat (7) tick;
    chk("tm_inst", inst, 9'h106);
    chk("tm_count7", inst_count, 7);
    stall = 1'b1; tick;
    chk("tm_stall_done", done, 0);
    chk("tm_stall_valid", inst_valid, 1);
    stall = 1'b0; branch = 1'b1; take = 1'b1; target = 8'h30; #1;
    chk("tm_en", imem_en, 0);
    tick; branch = 1'b0; take = 1'b0;
    chk("tm_done", done, 1);
    chk("tm_valid", inst_valid, 0);
    chk("tm_inst0", inst, 0);
    chk("tm_count8", inst_count, 8);
    chk("tm_en_halt", imem_en, 0);
    tick;
    chk("halt_done", done, 1);
    chk("halt_en", imem_en, 0);
    chk("halt_addr", imem_addr, 8);

    // Restart from HALT
    start = 1'b1; #1;
    chk("hs_en", imem_en, 1);
    chk("hs_addr", imem_addr, 0);
    tick;
    chk("hs_done", done, 0);
    chk("hs_count", inst_count, 0);
    chk("hs_pc", inst_pc, 0);
    chk("hs_valid", inst_valid, 1);
    // start stays asserted: ignored in RUN
    tick; start = 1'b0;
    chk("run_start_pc", inst_pc, 1);
    tick; tick;
    chk("mid_pc3", inst_pc, 3);
    reset = 1'b1; tick; reset = 1'b0;
    chk("mr_valid", inst_valid, 0);
    chk("mr_count", inst_count, 0);
    chk("mr_pc", inst_pc, 0);
    chk("mr_en", imem_en, 0);

    // 4-bit PC wrap and counter saturation
    start4 = 1'b1; tick; start4 = 1'b0;
    chk("w_pc14", inst_pc4, 14);
    tick; chk("w_pc15", inst_pc4, 15);
    tick; chk("w_pc0", inst_pc4, 0);
    tick; chk("w_pc1", inst_pc4, 1);
    chk("w_count3", inst_count4, 3);
    branch4 = 1'b1; take4 = 1'b1; target4 = 4'd15; #1;
    chk("w_br_addr", imem_addr4, 15);
    tick; branch4 = 1'b0; take4 = 1'b0;
    chk("w_br_pc15", inst_pc4, 15);
    chk("w_count4", inst_count4, 4);
    tick; chk("w_br_pc0", inst_pc4, 0);
    tick; tick;
    chk("w_count7", inst_count4, 7);
    tick;
    chk("w_sat", inst_count4, 7);
    chk("w_pc3", inst_pc4, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
